beat_timing_seq: RTL and testbench
==================================

// Module: beat_timing_seq
// PURPOSE
//  Beat sequencer for the hardwired controller: generates one-hot machine beats W1/W2/W3 from T3.
//  Honours controller requests SHORT (end after W1), LONG (add W3) and STOP (freeze).
//  Start/resume comes from the console QD button. Counts completed instructions.
//  Sits between the clock/console panel and the controller decode; all-beats-low means IDLE
//  (controller latches mode switches only then).
// PARAMETERS
//  ICNT_W       8  width of instruction counter ICNT (wraps)
//  SYNC_STAGES  2  QD synchroniser depth, >=2
// PORTS
//  T3        in   1       timing clock; all state updates on falling edge
//  CLR       in   1       reset CLR, asynchronous, active-low
//  QD        in   1       start/resume button, asynchronous, active-high
//  SHORT     in   1       from controller: current W1 is last beat
//  LONG      in   1       from controller: W2 continues to W3
//  STOP      in   1       from controller: freeze at end of current beat
//  W1,W2,W3  out  1 each  beat outputs, one-hot or all-low (IDLE)
//  BEAT_EN   out  1       1 only in RUN; downstream gates T3-qualified writes with it
//  BEAT_LAST out  1       comb: (W1&SHORT)|(W2&~LONG)|W3, qualified by non-IDLE
//  ICNT      out  ICNT_W  completed-instruction count
// BEHAVIOUR
//  Reset (CLR=0, async): state IDLE, W1=W2=W3=0, BEAT_EN=0, ICNT=0, sync flops 0.
//  QD: SYNC_STAGES-flop synchroniser + edge detect; qd_rise = last sync stage & ~delayed copy.
//   QD rising -> action on (SYNC_STAGES+1)th falling T3 edge; QD held high gives one rise only.
//  States: IDLE, RUN, PAUSE (2-bit reg + one-hot beat reg).
//   IDLE : W all low. qd_rise -> RUN, W1=1.
//   RUN  : at each falling edge: STOP=1 -> PAUSE, beat held (not advanced);
//          else advance: W1 -> (SHORT ? W1 : W2); W2 -> (LONG ? W3 : W1); W3 -> W1.
//   PAUSE: current beat's W stays high, BEAT_EN=0. qd_rise -> RUN and advance by the
//          same rule using SHORT/LONG seen at that edge. STOP ignored on the resume edge.
//  Priority: SHORT over LONG in W1; LONG ignored outside W2; SHORT ignored outside W1.
//  qd_rise ignored in RUN. STOP ignored in IDLE.
//  ICNT += 1 (mod 2^ICNT_W) on every advance out of a beat where BEAT_LAST=1
//   (RUN advance or PAUSE resume). No count on freeze.
//  Illegal beat encoding (0 or >1 hot outside IDLE) -> IDLE next edge, ICNT unchanged.
//  CLR mid-beat: immediate IDLE, counter cleared, partial instruction discarded.
// CONFIGURATION
//  BEAT_SINGLE_STEP_EN defined: extra input SSTEP (1 bit). SSTEP=1 in RUN acts as STOP=1
//   at end of every beat (one beat per QD press); SSTEP does not affect IDLE or PAUSE.
//  Not defined: no SSTEP port; behaviour identical to SSTEP=0.
// TESTING
//  CLR pulse low during W2 of RUN -> W=000, BEAT_EN=0, ICNT=0 immediately (before next T3).
//  QD rise, SHORT=1 always -> W1 after 3 falling edges, then W1 every beat, ICNT +1 per edge.
//  SHORT=0, LONG=1 -> W1,W2,W3,W1...; ICNT increments only leaving W3; 10 instr -> ICNT=10.
//  STOP=1 during W1 -> W1 held, BEAT_EN=0 for 20 edges; QD press -> W2, BEAT_EN=1.
//  ICNT_W=8, 256 short instrs from ICNT=0 -> ICNT wraps to 0, no glitch on W outputs.
//  BEAT_SINGLE_STEP_EN, SSTEP=1, LONG=1 -> each QD press advances one beat W1->W2->W3->W1.

Source files
------------

// File: rtl/beat_timing_seq.sv
// beat_timing_seq: one-hot W1/W2/W3 machine-beat sequencer, advancing on falling T3, started/resumed by QD.
// Optional feature macro BEAT_SINGLE_STEP_EN adds input SSTEP (one beat per QD press while running).
module beat_timing_seq #(
  parameter int ICNT_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              T3,
  input  logic              CLR,
  input  logic              QD,
  input  logic              SHORT,
  input  logic              LONG,
  input  logic              STOP,
`ifdef BEAT_SINGLE_STEP_EN
  input  logic              SSTEP,
`endif
  output logic              W1,
  output logic              W2,
  output logic              W3,
  output logic              BEAT_EN,
  output logic              BEAT_LAST,
  output logic [ICNT_W-1:0] ICNT,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t                 r_state;
  logic [2:0]             r_beat;      // {W3, W2, W1}
  logic                   r_beat_en;
  logic [ICNT_W-1:0]      r_icnt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_qd_d;

  logic       w_qd_rise;
  logic       w_stop;
  logic       w_beat_ok;
  logic       w_last;
  logic [2:0] w_next_beat;

  assign w_qd_rise = r_sync[SYNC_STAGES-1] & ~r_qd_d;

`ifdef BEAT_SINGLE_STEP_EN
  assign w_stop = STOP | SSTEP;
`else
  assign w_stop = STOP;
`endif

  assign w_beat_ok = (r_beat == 3'b001) || (r_beat == 3'b010) || (r_beat == 3'b100);

  // SHORT only matters in W1 and LONG only in W2, so SHORT wins by construction.
  assign w_last = (r_state != ST_IDLE) &
                  ((r_beat[0] & SHORT) | (r_beat[1] & ~LONG) | r_beat[2]);

  always_comb begin
    w_next_beat = 3'b000;
    case (r_beat)
      3'b001:  w_next_beat = SHORT ? 3'b001 : 3'b010;
      3'b010:  w_next_beat = LONG  ? 3'b100 : 3'b001;
      3'b100:  w_next_beat = 3'b001;
      default: w_next_beat = 3'b000;
    endcase
  end

  always_ff @(negedge T3 or negedge CLR) begin
    if (!CLR) begin
      r_state   <= ST_IDLE;
      r_beat    <= 3'b000;
      r_beat_en <= 1'b0;
      r_icnt    <= '0;
      r_sync    <= '0;
      r_qd_d    <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], QD};
      r_qd_d <= r_sync[SYNC_STAGES-1];
      case (r_state)
        ST_IDLE: begin
          if (w_qd_rise) begin
            r_state   <= ST_RUN;
            r_beat    <= 3'b001;
            r_beat_en <= 1'b1;
          end else begin
            r_beat    <= 3'b000;
            r_beat_en <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!w_beat_ok) begin
            r_state   <= ST_IDLE;
            r_beat    <= 3'b000;
            r_beat_en <= 1'b0;
          end else if (w_stop) begin
            r_state   <= ST_PAUSE;
            r_beat_en <= 1'b0;
          end else begin
            r_beat <= w_next_beat;
            if (w_last) r_icnt <= r_icnt + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (!w_beat_ok) begin
            r_state   <= ST_IDLE;
            r_beat    <= 3'b000;
            r_beat_en <= 1'b0;
          end else if (w_qd_rise) begin
            r_state   <= ST_RUN;
            r_beat_en <= 1'b1;
            r_beat    <= w_next_beat;
            if (w_last) r_icnt <= r_icnt + 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_beat    <= 3'b000;
          r_beat_en <= 1'b0;
        end
      endcase
    end
  end

  assign W1          = r_beat[0];
  assign W2          = r_beat[1];
  assign W3          = r_beat[2];
  assign BEAT_EN     = r_beat_en;
  assign BEAT_LAST   = w_last;
  assign ICNT        = r_icnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_beat_timing_seq.sv
// tb_beat_timing_seq: directed scenarios plus randomized traffic, checked every T3 cycle against a beat-level model.
module tb_beat_timing_seq;

  localparam int ICNT_W      = 8;
  localparam int SYNC_STAGES = 2;

  logic              T3 = 1'b0;
  logic              CLR, QD, SHORT, LONG, STOP, SSTEP;
  logic              W1, W2, W3, BEAT_EN, BEAT_LAST;
  logic [ICNT_W-1:0] ICNT;
  logic [1:0]        dbg_state;

  logic qd_i, short_i, long_i, stop_i, sstep_i;

  int n_tests = 0;
  int n_fail  = 0;

  // model: mode 0=idle 1=run 2=pause; beat 0=none, 1..3 = W1..W3
  int          m_mode;
  int          m_beat;
  int unsigned m_cnt;
  bit          qs[$];

  beat_timing_seq #(.ICNT_W(ICNT_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .T3(T3), .CLR(CLR), .QD(QD), .SHORT(SHORT), .LONG(LONG), .STOP(STOP),
`ifdef BEAT_SINGLE_STEP_EN
    .SSTEP(SSTEP),
`endif
    .W1(W1), .W2(W2), .W3(W3), .BEAT_EN(BEAT_EN), .BEAT_LAST(BEAT_LAST),
    .ICNT(ICNT), .o_dbg_state(dbg_state)
  );

  // clock / watchdog
  initial forever #5 T3 = ~T3;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] m_w();
    return (m_beat == 0) ? 3'b000 : (3'b001 << (m_beat - 1));
  endfunction

  function automatic logic m_last();
    if (m_mode == 0) return 1'b0;
    return (m_beat == 1 && short_i) || (m_beat == 2 && !long_i) || (m_beat == 3);
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_beat = 0;
    m_cnt  = 0;
    qs.delete();
    for (int i = 0; i <= SYNC_STAGES; i++) qs.push_back(1'b0);
  endtask

  // one falling T3 edge; a rise is seen when QD sampled SYNC_STAGES edges ago was 1 and the one before was 0
  task automatic model_edge();
    bit rise, stop_eff, last;
    int nxt;
    rise = qs[1] && !qs[0];
    stop_eff = stop_i;
`ifdef BEAT_SINGLE_STEP_EN
    stop_eff = stop_i || sstep_i;
`endif
    last = m_last();
    nxt  = (m_beat == 1) ? (short_i ? 1 : 2) : (m_beat == 2) ? (long_i ? 3 : 1) : 1;
    case (m_mode)
      0: if (rise) begin m_mode = 1; m_beat = 1; end
      1: if (stop_eff) m_mode = 2;
         else begin
           if (last) m_cnt++;
           m_beat = nxt;
         end
      default: if (rise) begin
           m_mode = 1;
           if (last) m_cnt++;
           m_beat = nxt;
         end
    endcase
    qs.push_back(qd_i);
    void'(qs.pop_front());
  endtask

  task automatic check_outputs(input string ph);
    check_eq({ph, "_w"},       {W3, W2, W1}, m_w());
    check_eq({ph, "_beat_en"}, BEAT_EN, (m_mode == 1));
    check_eq({ph, "_icnt"},    ICNT, m_cnt & ((1 << ICNT_W) - 1));
    check_eq({ph, "_last"},    BEAT_LAST, m_last());
    check_eq({ph, "_idle"},    (dbg_state == 2'd0), (m_mode == 0));
  endtask

  // driver: one T3 cycle, optional asynchronous clear mid-cycle
  task automatic cycle(input bit do_clr);
    @(posedge T3);
    #1;
    QD = qd_i; SHORT = short_i; LONG = long_i; STOP = stop_i; SSTEP = sstep_i;
    #1;
    check_eq("pre_last", BEAT_LAST, m_last());
    if (do_clr) begin
      CLR = 1'b0;
      #1;
      check_eq("clr_w", {W3, W2, W1}, 3'b000);
      check_eq("clr_beat_en", BEAT_EN, 1'b0);
      check_eq("clr_icnt", ICNT, 0);
      model_reset();
      CLR = 1'b1;
    end
    @(negedge T3);
    model_edge();
    #1;
    check_outputs("cyc");
  endtask

  task automatic do_reset();
    @(posedge T3);
    #1;
    CLR = 1'b0;
    qd_i = 0; short_i = 0; long_i = 0; stop_i = 0; sstep_i = 0;
    QD = 0; SHORT = 0; LONG = 0; STOP = 0; SSTEP = 0;
    model_reset();
    @(negedge T3);
    #1;
    check_outputs("reset");
    @(posedge T3);
    #2;
    CLR = 1'b1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0);
  endtask

  initial begin
    int edges;
    bit found;
    CLR = 1'b1;
    qd_i = 0; short_i = 0; long_i = 0; stop_i = 0; sstep_i = 0;
    QD = 0; SHORT = 0; LONG = 0; STOP = 0; SSTEP = 0;
    model_reset();

    // start latency with SHORT held: W1 on the third falling edge, then one instruction per edge
    do_reset();
    qd_i = 1; short_i = 1;
    edges = 0; found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      cycle(1'b0);
      edges++;
      if (W1) found = 1;
    end
    check_eq("qd_latency", edges, 3);
    cycles(5);
    check_eq("short_icnt", ICNT, 5);

    // clear during W2
    do_reset();
    qd_i = 1;
    cycles(4);
    check_eq("in_w2", {W3, W2, W1}, 3'b010);
    cycle(1'b1);

    // LONG: W1,W2,W3 per instruction, 10 instructions
    do_reset();
    qd_i = 1; long_i = 1;
    cycles(3);
    qd_i = 0;
    cycles(30);
    check_eq("long_icnt", ICNT, 10);
    check_eq("long_w", {W3, W2, W1}, 3'b001);

    // STOP in W1, hold 20 edges, resume to W2
    do_reset();
    qd_i = 1;
    cycles(3);
    qd_i = 0; stop_i = 1;
    cycle(1'b0);
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0);
      check_eq("pause_w", {W3, W2, W1}, 3'b001);
      check_eq("pause_en", BEAT_EN, 1'b0);
    end
    qd_i = 1;
    cycles(3);
    check_eq("resume_w", {W3, W2, W1}, 3'b010);
    check_eq("resume_en", BEAT_EN, 1'b1);

    // 256 short instructions wrap the counter
    do_reset();
    qd_i = 1; short_i = 1;
    cycles(3);
    for (int k = 0; k < 256; k++) begin
      cycle(1'b0);
      check_eq("wrap_w", {W3, W2, W1}, 3'b001);
    end
    check_eq("wrap_icnt", ICNT, 0);

`ifdef BEAT_SINGLE_STEP_EN
    // single step: each QD press advances exactly one beat
    do_reset();
    sstep_i = 1; long_i = 1; qd_i = 1;
    cycles(4);
    check_eq("ss_start", {W3, W2, W1}, 3'b001);
    for (int p = 0; p < 3; p++) begin
      qd_i = 0; cycles(4);
      qd_i = 1; cycles(4);
      check_eq("ss_step", {W3, W2, W1}, (p == 0) ? 3'b010 : (p == 1) ? 3'b100 : 3'b001);
    end
    check_eq("ss_icnt", ICNT, 1);
`endif

    // randomized traffic with occasional clears
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 5) == 0) qd_i = ~qd_i;
      short_i = ($urandom_range(0, 3) == 0);
      long_i  = $urandom_range(0, 1) == 1;
      stop_i  = ($urandom_range(0, 9) == 0);
`ifdef BEAT_SINGLE_STEP_EN
      sstep_i = ($urandom_range(0, 4) == 0);
`endif
      cycle($urandom_range(0, 199) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
